// File: rtl/stage_seq_pkg.sv
// Shared constants for the stage sequencer: control operation encoding and the FETCH stage index.
package stage_seq_pkg;

   typedef enum logic [1:0] {
      CTRL_TRAP    = 2'b00,
      CTRL_EXT_INT = 2'b01,
      CTRL_SW_INT  = 2'b10,
      CTRL_NORMAL  = 2'b11
   } ctrl_op_e;

   localparam int unsigned STAGE_FETCH = 0;

endpackage

// File: rtl/stage_sequencer_if.sv
// Decoder/CSR/datapath-facing signal bundle of the stage sequencer.
interface stage_sequencer_if
   import stage_seq_pkg::*;
#(
   parameter int unsigned NUM_STAGES = 8,
   parameter int unsigned FAULT_W    = 3
);
   logic [NUM_STAGES-1:0] stage_skip;
   logic                  stall;
   logic                  fault_valid;
   logic [FAULT_W-1:0]    fault_num;
   logic                  ext_int_pending;
   logic                  sw_int_pending;
   logic [NUM_STAGES-1:0] stage_active;
   ctrl_op_e              control_op;
   logic [FAULT_W-1:0]    trap_num;
   logic                  retire;
   logic                  halted;
   logic [31:0]           cycle_count;
   logic [31:0]           retire_count;

   modport master (
      output stage_skip, stall, fault_valid, fault_num, ext_int_pending, sw_int_pending,
      input  stage_active, control_op, trap_num, retire, halted, cycle_count, retire_count
   );

   modport slave (
      input  stage_skip, stall, fault_valid, fault_num, ext_int_pending, sw_int_pending,
      output stage_active, control_op, trap_num, retire, halted, cycle_count, retire_count
   );
endinterface

// File: rtl/stage_next_sel.sv
// Finds the next non-skipped stage above the current one-hot stage; wraps to FETCH if none.
module stage_next_sel
   import stage_seq_pkg::*;
#(
   parameter int unsigned NUM_STAGES = 8
) (
   input  logic [NUM_STAGES-1:0] cur_i,
   input  logic [NUM_STAGES-1:0] skip_i,
   output logic [NUM_STAGES-1:0] next_o,
   output logic                  wrap_o
);
   logic [NUM_STAGES-1:0] above;
   logic [NUM_STAGES-1:0] cand;
   logic                  seen;
   logic                  found;

   always_comb begin
      above = '0;
      seen  = 1'b0;
      for (int j = 0; j < int'(NUM_STAGES); j++) begin
         above[j] = seen;
         seen     = seen | cur_i[j];
      end
      cand   = above & ~skip_i;
      next_o = '0;
      found  = 1'b0;
      for (int j = 0; j < int'(NUM_STAGES); j++) begin
         if (cand[j] && !found) begin
            next_o[j] = 1'b1;
            found     = 1'b1;
         end
      end
      wrap_o = !found;
      if (!found) next_o[STAGE_FETCH] = 1'b1;
   end
endmodule

// File: rtl/stage_sequencer.sv
// One-hot multi-cycle stage sequencer with skip mask, stalls, traps, interrupts and halt.
// Optional STAGE_SEQ_COUNTERS_EN adds free-running cycle and retire counters.
module stage_sequencer
   import stage_seq_pkg::*;
#(
   parameter int unsigned NUM_STAGES   = 8,
   parameter int unsigned DECODE_STAGE = 1,
   parameter int unsigned FAULT_W      = 3
) (
   input  logic              clk,
   input  logic              reset,
   stage_sequencer_if.slave  bus
);
   localparam logic [NUM_STAGES-1:0] FetchOneHot = NUM_STAGES'(1) << STAGE_FETCH;

   logic [NUM_STAGES-1:0] stage_q, stage_d;
   logic [NUM_STAGES-1:0] skip_q, skip_d;
   ctrl_op_e              ctrl_q, ctrl_d;
   logic [FAULT_W-1:0]    trap_q, trap_d;
   logic                  halted_q, halted_d;

   logic [NUM_STAGES-1:0] skip_in;
   logic [NUM_STAGES-1:0] eff_skip;
   logic [NUM_STAGES-1:0] next_stage;
   logic                  wrap;
   logic                  retire;

   // The decode stage itself advances with the freshly decoded mask, not the stale register.
   always_comb begin
      skip_in = bus.stage_skip;
      for (int i = 0; i <= int'(DECODE_STAGE); i++) skip_in[i] = 1'b0;
      eff_skip = stage_q[DECODE_STAGE] ? skip_in : skip_q;
   end

   stage_next_sel #(
      .NUM_STAGES(NUM_STAGES)
   ) u_next_sel (
      .cur_i (stage_q),
      .skip_i(eff_skip),
      .next_o(next_stage),
      .wrap_o(wrap)
   );

   assign retire = (ctrl_q == CTRL_NORMAL) && wrap && !bus.stall && !bus.fault_valid && !halted_q;

   always_comb begin
      stage_d  = stage_q;
      skip_d   = skip_q;
      ctrl_d   = ctrl_q;
      trap_d   = trap_q;
      halted_d = halted_q;
      if (halted_q) begin
         // frozen until reset
      end else if (bus.fault_valid) begin
         if (ctrl_q == CTRL_NORMAL) begin
            stage_d = FetchOneHot;
            skip_d  = '0;
            ctrl_d  = CTRL_TRAP;
            trap_d  = bus.fault_num;
         end else begin
            halted_d = 1'b1;
         end
      end else if (!bus.stall) begin
         stage_d = next_stage;
         if (stage_q[DECODE_STAGE]) skip_d = skip_in;
         if (wrap) begin
            skip_d = '0;
            if (bus.ext_int_pending)     ctrl_d = CTRL_EXT_INT;
            else if (bus.sw_int_pending) ctrl_d = CTRL_SW_INT;
            else                         ctrl_d = CTRL_NORMAL;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stage_q  <= FetchOneHot;
         skip_q   <= '0;
         ctrl_q   <= CTRL_NORMAL;
         trap_q   <= '0;
         halted_q <= 1'b0;
      end else begin
         stage_q  <= stage_d;
         skip_q   <= skip_d;
         ctrl_q   <= ctrl_d;
         trap_q   <= trap_d;
         halted_q <= halted_d;
      end
   end

   assign bus.stage_active = stage_q;
   assign bus.control_op   = ctrl_q;
   assign bus.trap_num     = trap_q;
   assign bus.retire       = retire;
   assign bus.halted       = halted_q;

`ifdef STAGE_SEQ_COUNTERS_EN
   logic [31:0] cycle_cnt_q, cycle_cnt_d;
   logic [31:0] retire_cnt_q, retire_cnt_d;

   always_comb begin
      cycle_cnt_d  = cycle_cnt_q;
      retire_cnt_d = retire_cnt_q;
      if (!halted_q) cycle_cnt_d  = cycle_cnt_q + 32'd1;
      if (retire)    retire_cnt_d = retire_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_cnt_q  <= '0;
         retire_cnt_q <= '0;
      end else begin
         cycle_cnt_q  <= cycle_cnt_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   assign bus.cycle_count  = cycle_cnt_q;
   assign bus.retire_count = retire_cnt_q;
`else
   assign bus.cycle_count  = '0;
   assign bus.retire_count = '0;
`endif
endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: advance, skip, stall, trap, interrupts, halt and reset.
module tb_stage_sequencer;
   import stage_seq_pkg::*;

`ifdef STAGE_SEQ_COUNTERS_EN
   localparam bit CntEn = 1'b1;
`else
   localparam bit CntEn = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   int   n_vec = 0;
   int   n_err = 0;

   stage_sequencer_if #(.NUM_STAGES(8), .FAULT_W(3)) bus ();

   stage_sequencer #(
      .NUM_STAGES  (8),
      .DECODE_STAGE(1),
      .FAULT_W     (3)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      n_vec++;
      assert ($onehot(bus.stage_active)) else begin
         n_err++;
         $error("FAIL onehot: observed %0h expected one-hot", bus.stage_active);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] cnt(input int n);
      return CntEn ? 32'(n) : 32'd0;
   endfunction

   initial begin
      logic [7:0] seq2 [4];
      seq2 = '{8'h01, 8'h02, 8'h08, 8'h10};
      reset               = 1'b1;
      bus.stage_skip      = '0;
      bus.stall           = 1'b0;
      bus.fault_valid     = 1'b0;
      bus.fault_num       = '0;
      bus.ext_int_pending = 1'b0;
      bus.sw_int_pending  = 1'b0;
      cyc();
      cyc();
      #2;
      check("rst_stage", bus.stage_active, 32'h01);
      check("rst_ctrl", bus.control_op, 32'h3);
      check("rst_trap", bus.trap_num, 32'h0);
      check("rst_halted", bus.halted, 32'h0);
      check("rst_cycles", bus.cycle_count, 32'h0);
      check("rst_retires", bus.retire_count, 32'h0);
      reset = 1'b0;

      // full walk through all eight stages
      for (int i = 0; i < 8; i++) begin
         #2;
         check("walk_stage", bus.stage_active, 32'h1 << i);
         check("walk_retire", bus.retire, (i == 7) ? 32'h1 : 32'h0);
         cyc();
      end
      #2;
      check("walk_wrap", bus.stage_active, 32'h01);
      check("walk_cycles", bus.cycle_count, cnt(8));
      check("walk_retires", bus.retire_count, cnt(1));

      // skip mask E4 latched at stage 1
      bus.stage_skip = 8'hE4;
      for (int k = 0; k < 4; k++) begin
         #2;
         check("skip_stage", bus.stage_active, 32'(seq2[k]));
         check("skip_retire", bus.retire, (k == 3) ? 32'h1 : 32'h0);
         cyc();
      end
      bus.stage_skip = '0;
      #2;
      check("skip_wrap", bus.stage_active, 32'h01);
      check("skip_cycles", bus.cycle_count, cnt(12));
      check("skip_retires", bus.retire_count, cnt(2));

      // three stall cycles in stage 3
      cyc();
      cyc();
      cyc();
      bus.stall = 1'b1;
      #2;
      check("stall_enter", bus.stage_active, 32'h08);
      check("stall_retire", bus.retire, 32'h0);
      cyc();
      cyc();
      #2;
      check("stall_hold", bus.stage_active, 32'h08);
      check("stall_cycles", bus.cycle_count, cnt(17));
      cyc();
      bus.stall = 1'b0;
      #2;
      check("stall_last", bus.stage_active, 32'h08);
      cyc();
      #2;
      check("stall_exit", bus.stage_active, 32'h10);
      check("stall_cycles2", bus.cycle_count, cnt(19));

      // fault overrides stall in stage 4
      bus.stall       = 1'b1;
      bus.fault_valid = 1'b1;
      bus.fault_num   = 3'd5;
      #2;
      check("fault_no_retire", bus.retire, 32'h0);
      cyc();
      bus.stall       = 1'b0;
      bus.fault_valid = 1'b0;
      bus.fault_num   = 3'd0;
      #2;
      check("trap_stage", bus.stage_active, 32'h01);
      check("trap_ctrl", bus.control_op, 32'h0);
      check("trap_num", bus.trap_num, 32'h5);
      for (int i = 0; i < 8; i++) begin
         #2;
         check("trap_walk", bus.stage_active, 32'h1 << i);
         check("trap_no_retire", bus.retire, 32'h0);
         cyc();
      end
      #2;
      check("trap_return_ctrl", bus.control_op, 32'h3);
      check("trap_return_stage", bus.stage_active, 32'h01);
      check("trap_cycles", bus.cycle_count, cnt(28));
      check("trap_retires", bus.retire_count, cnt(2));

      // minimum-latency instruction; sw int outside the wrap cycle is ignored
      bus.stage_skip     = 8'hFC;
      bus.sw_int_pending = 1'b1;
      cyc();
      bus.ext_int_pending = 1'b1;
      #2;
      check("min_stage", bus.stage_active, 32'h02);
      check("int_not_sampled", bus.control_op, 32'h3);
      check("min_retire", bus.retire, 32'h1);
      cyc();
      bus.ext_int_pending = 1'b0;
      bus.sw_int_pending  = 1'b0;
      #2;
      check("int_stage", bus.stage_active, 32'h01);
      check("int_priority", bus.control_op, 32'h1);

      // fault inside the interrupt sequence halts
      bus.fault_valid = 1'b1;
      bus.fault_num   = 3'd6;
      cyc();
      bus.fault_valid = 1'b0;
      bus.fault_num   = 3'd0;
      cyc();
      cyc();
      #2;
      check("halt_flag", bus.halted, 32'h1);
      check("halt_stage", bus.stage_active, 32'h01);
      check("halt_ctrl", bus.control_op, 32'h1);
      check("halt_trap", bus.trap_num, 32'h5);
      check("halt_retire", bus.retire, 32'h0);
      check("halt_cycles", bus.cycle_count, cnt(31));
      check("halt_retires", bus.retire_count, cnt(3));

      reset = 1'b1;
      cyc();
      reset = 1'b0;
      #2;
      check("rerst_stage", bus.stage_active, 32'h01);
      check("rerst_ctrl", bus.control_op, 32'h3);
      check("rerst_halted", bus.halted, 32'h0);
      check("rerst_trap", bus.trap_num, 32'h0);
      check("rerst_cycles", bus.cycle_count, 32'h0);

      // reset mid-stall
      bus.stage_skip = '0;
      cyc();
      bus.stall = 1'b1;
      cyc();
      #2;
      check("pre_rst_stall", bus.stage_active, 32'h02);
      reset = 1'b1;
      cyc();
      reset     = 1'b0;
      bus.stall = 1'b0;
      #2;
      check("stall_rst_stage", bus.stage_active, 32'h01);
      check("stall_rst_ctrl", bus.control_op, 32'h3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
